// File: rtl/jk_access_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jk_access_ctrl_if
//  Purpose  : Requester/JK-cell bundle shared between jk_access_ctrl and its users.
//  Revision : 1.0
// ============================================================================
interface jk_access_ctrl_if #(
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [2*N-1:0] op;
    logic           q;
    logic           j;
    logic           k;
    logic           dev_rst;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           rdata;
    logic           mismatch;
    logic [7:0]     err_cnt;
    logic           busy;

    modport master (
        output req, op, q,
        input  j, k, dev_rst, gnt, done, rdata, mismatch, err_cnt, busy
    );

    modport slave (
        input  req, op, q,
        output j, k, dev_rst, gnt, done, rdata, mismatch, err_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/jk_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jk_access_ctrl
//  Purpose  : Round-robin sharing of one JK cell among N requesters, with
//             truth-table checking of every result.
//  Revision : 1.0
// ============================================================================
module jk_access_ctrl #(
    parameter int N = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    jk_access_ctrl_if.slave bus
);
    localparam int c_PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_IDLE    = 2'd1,
        S_ISSUE   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [c_PW-1:0] ptr_q, ptr_d;
    logic [c_PW-1:0] sel_q, sel_d;
    logic [1:0]      op_q, op_d;
    logic            q_prev_q, q_prev_d;
    logic            j_q, j_d, k_q, k_d;
    logic            dev_rst_q, dev_rst_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic            rdata_q, rdata_d;
    logic            mismatch_q, mismatch_d;
    logic            busy_q, busy_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            arb_hit;
    logic [c_PW-1:0] arb_sel;
    logic [c_PW:0]   w_idx;
    logic            w_expect;

    // Search upward from ptr with wrap; w_idx is reduced mod N without a divider.
    always_comb begin
        arb_hit = 1'b0;
        arb_sel = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, ptr_q} + (c_PW+1)'(i);
            if (w_idx >= (c_PW+1)'(N)) begin
                w_idx = w_idx - (c_PW+1)'(N);
            end
            if (!arb_hit && bus.req[w_idx[c_PW-1:0]]) begin
                arb_hit = 1'b1;
                arb_sel = w_idx[c_PW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        op_d       = op_q;
        q_prev_d   = q_prev_q;
        j_d        = j_q;
        k_d        = k_q;
        dev_rst_d  = 1'b0;
        gnt_d      = gnt_q;
        done_d     = '0;
        rdata_d    = rdata_q;
        mismatch_d = 1'b0;
        busy_d     = busy_q;
        err_cnt_d  = err_cnt_q;
        w_expect   = 1'b0;

        case (state_q)
            S_INIT: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (arb_hit) begin
                    state_d    = S_ISSUE;
                    sel_d      = arb_sel;
                    op_d       = bus.op[{arb_sel, 1'b0} +: 2];
                    q_prev_d   = bus.q;
                    gnt_d      = {{(N-1){1'b0}}, 1'b1} << arb_sel;
                    {j_d, k_d} = op_d;
                    busy_d     = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
                j_d     = 1'b0;
                k_d     = 1'b0;
            end
            S_CAPTURE: begin
                case (op_q)
                    2'b00:   w_expect = q_prev_q;
                    2'b01:   w_expect = 1'b0;
                    2'b10:   w_expect = 1'b1;
                    default: w_expect = ~q_prev_q;
                endcase
                state_d = S_IDLE;
                rdata_d = bus.q;
                done_d  = gnt_q;
                gnt_d   = '0;
                busy_d  = 1'b0;
                if (bus.q != w_expect) begin
                    mismatch_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                ptr_d = (sel_q == c_PW'(N-1)) ? '0 : sel_q + 1'b1;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            ptr_q      <= '0;
            sel_q      <= '0;
            op_q       <= 2'b00;
            q_prev_q   <= 1'b0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            dev_rst_q  <= 1'b1;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= 1'b0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            op_q       <= op_d;
            q_prev_q   <= q_prev_d;
            j_q        <= j_d;
            k_q        <= k_d;
            dev_rst_q  <= dev_rst_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.j        = j_q;
    assign bus.k        = k_q;
    assign bus.dev_rst  = dev_rst_q;
    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.mismatch = mismatch_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.busy     = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_jk_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_jk_access_ctrl
//  Purpose  : Random and directed stimulus for jk_access_ctrl against an
//             operation-timeline reference model and a behavioural JK cell.
//  Revision : 1.0
// ============================================================================
module tb_jk_access_ctrl;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jk_access_ctrl_if #(.N(N)) bus ();

    jk_access_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural JK cell; force_q0 models a stuck-at-0 q line.
    logic cell_q   = 1'b0;
    logic force_q0 = 1'b0;
    always @(posedge clk) begin
        if (bus.dev_rst) cell_q <= 1'b0;
        else begin
            case ({bus.j, bus.k})
                2'b01:   cell_q <= 1'b0;
                2'b10:   cell_q <= 1'b1;
                2'b11:   cell_q <= ~cell_q;
                default: ;
            endcase
        end
    end
    assign bus.q = force_q0 ? 1'b0 : cell_q;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: m_age is -1 with no operation, else edges since grant.
    bit         m_init;
    int         m_age, m_ptr, m_sel, m_err;
    logic [1:0] m_op;
    logic       m_qprev, ref_cell;
    logic [N-1:0] e_gnt, e_done;
    logic       e_j, e_k, e_dev_rst, e_rdata, e_mis, e_busy;
    logic [7:0] e_err;

    function automatic logic jk_next(input logic [1:0] op, input logic qp);
        case (op)
            2'b00:   return qp;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~qp;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_init = 1'b1; m_age = -1; m_ptr = 0; m_sel = 0; m_err = 0;
        m_op = 2'b00; m_qprev = 1'b0; ref_cell = 1'b0;
        e_gnt = '0; e_done = '0; e_j = 1'b0; e_k = 1'b0; e_dev_rst = 1'b1;
        e_rdata = 1'b0; e_mis = 1'b0; e_busy = 1'b0; e_err = 8'd0;
    endtask

    task automatic model_step();
        logic qseen;
        bit   found;
        qseen  = force_q0 ? 1'b0 : ref_cell;
        e_done = '0;
        e_mis  = 1'b0;
        if (m_init) begin
            m_init = 1'b0; e_dev_rst = 1'b0; ref_cell = 1'b0;
        end else if (m_age == 0) begin
            ref_cell = jk_next(m_op, ref_cell);
            e_j = 1'b0; e_k = 1'b0; m_age = 1;
        end else if (m_age == 1) begin
            e_rdata = qseen;
            e_done[m_sel] = 1'b1;
            if (qseen != jk_next(m_op, m_qprev)) begin
                e_mis = 1'b1;
                if (m_err < 255) m_err++;
            end
            e_err  = 8'(m_err);
            m_ptr  = (m_sel + 1) % N;
            e_gnt  = '0; e_busy = 1'b0; m_age = -1;
        end else begin
            e_j = 1'b0; e_k = 1'b0;
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!found && bus.req[(m_ptr + i) % N]) begin
                    found   = 1'b1;
                    m_sel   = (m_ptr + i) % N;
                end
            end
            if (found) begin
                m_op    = bus.op[2*m_sel +: 2];
                m_qprev = qseen;
                e_gnt   = '0;
                e_gnt[m_sel] = 1'b1;
                e_j = m_op[1]; e_k = m_op[0];
                e_busy = 1'b1; m_age = 0;
            end
        end
    endtask

    task automatic check_all();
        check_eq("gnt",      32'(bus.gnt),  32'(e_gnt));
        check_eq("done",     32'(bus.done), 32'(e_done));
        check_eq("rdata",    32'(bus.rdata), 32'(e_rdata));
        check_eq("mismatch", 32'(bus.mismatch), 32'(e_mis));
        check_eq("err_cnt",  32'(bus.err_cnt), 32'(e_err));
        check_eq("busy",     32'(bus.busy), 32'(e_busy));
        check_eq("j",        32'(bus.j),    32'(e_j));
        check_eq("k",        32'(bus.k),    32'(e_k));
        check_eq("dev_rst",  32'(bus.dev_rst), 32'(e_dev_rst));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drop_on_done();
        for (int i = 0; i < N; i++) if (e_done[i]) bus.req[i] = 1'b0;
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (e_done[i]) begin
                if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
            end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                bus.req[i] = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) bus.op[2*i +: 2] = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 15) == 0) force_q0 = ~force_q0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && !(bus.req == '0 && m_age == -1); c++) begin
            step_cycle();
            drop_on_done();
        end
        check_eq("drain_idle", 32'(bus.req == '0 && m_age == -1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ndone;
        bus.req = '0;
        bus.op  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Set from requester 0 right after reset release.
        bus.req[0] = 1'b1; bus.op[1:0] = 2'b10;
        repeat (6) begin step_cycle(); drop_on_done(); end
        drain();

        // Two toggles back to back from requester 1, starting at q=1.
        bus.req[1] = 1'b1; bus.op[3:2] = 2'b11;
        ndone = 0;
        for (int c = 0; c < 12 && ndone < 2; c++) begin
            step_cycle();
            if (e_done[1]) ndone++;
            if (ndone == 2) bus.req[1] = 1'b0;
        end
        drain();

        // All four requesting hold ops: strict rotation.
        bus.op = '0; bus.req = '1;
        repeat (16) step_cycle();
        bus.req = '0;
        drain();

        // Op of the granted requester rewritten after grant.
        bus.req[2] = 1'b1; bus.op[5:4] = 2'b10;
        for (int c = 0; c < 5 && m_age != 0; c++) step_cycle();
        bus.op[5:4] = 2'b01;
        repeat (4) begin step_cycle(); drop_on_done(); end
        drain();

        // Reset in the ISSUE cycle drops the operation.
        bus.req[3] = 1'b1; bus.op[7:6] = 2'b10;
        for (int c = 0; c < 5 && m_age != 0; c++) step_cycle();
        check_eq("rst_wait_issue", 32'(m_age == 0), 32'd1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        bus.req = '1; bus.op = '0;
        step_cycle();
        rst_n = 1'b1;
        repeat (3) step_cycle();
        bus.req = '0;
        drain();

        // Random traffic with occasional stuck q.
        repeat (600) begin
            step_cycle();
            drive_random();
        end
        for (int i = 0; i < N; i++) if (!e_done[i] && !(m_age >= 0 && m_sel == i)) bus.req[i] = 1'b0;
        drain();

        // Forced mismatches until the counter saturates.
        force_q0 = 1'b1;
        bus.op[1:0] = 2'b10; bus.req = 4'b0001;
        repeat (910) step_cycle();
        bus.req = '0;
        drain();
        check_eq("err_cnt_sat", 32'(bus.err_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/jk_access_ctrl.md
# jk_access_ctrl

Round-robin controller that shares one JK flip-flop (the D-based JK cell with ports j, k, clk, rst, q, qbar) among N requesters. It owns the cell's j/k/rst inputs, runs a per-operation INIT/IDLE/ISSUE/CAPTURE sequence, and returns the post-operation q to the granted requester. It also checks q against the JK truth table and counts mismatches. It sits between requester logic and the JK cell, which it drives directly.

## Interface
- N, default 4: number of requesters, range 2..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  request per requester; level, held until the matching done.
- op  in  2N  operation of requester i at op[2i+1:2i]: 00 hold, 01 reset, 10 set, 11 toggle. Sampled only at grant.
- q  in  1  q output of the JK cell.
- j, k  out  1 each  registered drive to the JK cell.
- dev_rst  out  1  active-high reset to the JK cell.
- gnt  out  N  one-hot grant, registered.
- done  out  N  one-hot, 1-cycle completion pulse.
- rdata  out  1  q captured for the completed op; valid while done is non-zero, and held until the next done.
- mismatch  out  1  1-cycle pulse together with done when q differs from the expected value.
- err_cnt  out  8  saturating mismatch count.
- busy  out  1  high in ISSUE and CAPTURE.

## Operation
- States:
  - INIT: dev_rst=1. Requests are ignored. Goes to IDLE after 1 cycle.
  - IDLE: arbitrate.
  - ISSUE: drive j/k for 1 cycle.
  - CAPTURE: sample q.
- IDLE:
  - If req is non-zero, select the first set bit searching from ptr upward, with wrap-around.
  - Register gnt[sel]=1 and {j,k}=op[sel].
  - Register q_prev=q.
  - Go to ISSUE.
  - With no request, stay in IDLE with j=k=0.
- ISSUE: the cell samples j/k at the end of this cycle. Then go to CAPTURE with {j,k}=00.
- CAPTURE, on exit:
  - rdata=q.
  - done[sel]=1 for 1 cycle.
  - expected value: hold gives q_prev, reset gives 0, set gives 1, toggle gives ~q_prev.
  - If q != expected: mismatch=1 and err_cnt+=1, saturating at 255.
  - ptr=(sel+1) mod N.
  - gnt=0.
  - Go to IDLE.
- In the IDLE cycle where done is high, arbitration runs normally. A requester that still holds req is treated as a new request, so the round-robin pointer already skips it.
- The op field of the granted requester is sampled only in the IDLE cycle that grants. Later changes have no effect on that operation.
- Requests that arrive while busy wait. The controller has no queueing beyond the level req.

## Timing
- Reset asserted (asynchronous):
  - state=INIT, dev_rst=1.
  - j=k=0, gnt=0, done=0, rdata=0, mismatch=0, err_cnt=0, busy=0, ptr=0.
- First edge after reset release: INIT to IDLE, dev_rst falls to 0. The cell then holds q=0.
- Reset mid-operation (ISSUE or CAPTURE): the operation is dropped and no done is issued. The sequence restarts at INIT.
- Per-operation latency, with req seen at edge E0 in IDLE:
  - gnt, j/k and busy are valid after E0.
  - The cell updates q at E1.
  - done, rdata and mismatch are valid after E2, for the single cycle up to E3.
- Throughput: 1 operation per 3 cycles with continuous requests.
- dev_rst is registered and set asynchronously by rst. j/k never change in the same cycle that dev_rst is high.
- gnt is high for exactly the 2 cycles spanning ISSUE and CAPTURE. done follows in the next cycle, when gnt is already 0.

## Test plan
- Reset release, then req[0]=1 with op=10 (set):
  - gnt=0001 and j,k=1,0 in the ISSUE cycle.
  - done=0001 2 cycles later, rdata=1, mismatch=0.
- With q=1, req[1] toggle, then req[1] toggle:
  - First done gives rdata=0, second gives rdata=1.
  - j,k=1,1 for exactly one cycle each time.
- req=1111 held with hold ops:
  - Grant order 0,1,2,3,0, one done every 3 cycles.
  - No requester is granted twice before the others.
- The bench forces q=0 after a set op:
  - mismatch pulses with done and err_cnt=1.
  - 300 forced mismatches leave err_cnt=255.
- Reset asserted during ISSUE:
  - Outputs go to reset values immediately and dev_rst=1.
  - No done pulse, and after release the first op is granted to requester 0.
- op changed while gnt is high (set changed to reset): the response still reflects set, so rdata=1 and mismatch=0.
